// File: rtl/ec11_pkg.sv
// Shared types and step patterns for the EC11 quadrature generator.
// Command codes, FSM states and the A/B detent sequences live here.
package ec11_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_LEFT  = 2'b01,
        CMD_RIGHT = 2'b10,
        CMD_PRESS = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        PHASE,
        PRESS_LOW,
        PRESS_HIGH
    } state_e;

    typedef struct packed {
        cmd_e       code;
        logic [7:0] count;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Index 0 is the first pattern after leaving detent 11.
    localparam logic [3:0][1:0] LEFT_SEQ  = {2'b11, 2'b01, 2'b00, 2'b10};
    localparam logic [3:0][1:0] RIGHT_SEQ = {2'b11, 2'b10, 2'b00, 2'b01};

    function automatic logic [1:0] seq_pat(input logic       right,
                                           input logic [1:0] idx);
        return right ? RIGHT_SEQ[idx] : LEFT_SEQ[idx];
    endfunction

endpackage

// File: rtl/ec11_cmd_fifo.sv
// Command FIFO for ec11_quad_gen: first-word-fall-through, power-of-two
// depth, pointers wrapped with a mask.
module ec11_cmd_fifo
    import ec11_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [CMD_W-1:0] wdata_i,
    input  logic             pop_i,
    output logic [CMD_W-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] MASK     = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("ec11_cmd_fifo: DEPTH must be a power of two >= 2");
    end

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees a slot on the same edge, so a full FIFO may still take a push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q + AW'(1)) & MASK;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q + AW'(1)) & MASK;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ec11_quad_gen.sv
// EC11 rotary-encoder emulator: queued step/press commands drive A/B/SW.
// Define EC11_QUAD_GEN_BOUNCE_EN to add contact bounce before each edge.
module ec11_quad_gen
    import ec11_pkg::*;
#(
    parameter int PHASE_CYCLES  = 100000,
    parameter int PRESS_CYCLES  = 2500000,
    parameter int FIFO_DEPTH    = 4,
    parameter int BOUNCE_CYCLES = 500
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_code,
    input  logic [7:0] cmd_count,
    output logic       enc_a,
    output logic       enc_b,
    output logic       enc_sw,
    output logic       busy,
    output logic       done_pulse
);

    localparam int CMAX = (PHASE_CYCLES > PRESS_CYCLES) ? PHASE_CYCLES
                                                        : PRESS_CYCLES;
    localparam int CW = $clog2(CMAX);
    localparam logic [CW-1:0] PH_LAST = CW'(PHASE_CYCLES - 1);
    localparam logic [CW-1:0] PR_LAST = CW'(PRESS_CYCLES - 1);

    if (PHASE_CYCLES < 2) begin : g_bad_phase
        $error("ec11_quad_gen: PHASE_CYCLES must be >= 2");
    end
    if (PRESS_CYCLES < 1) begin : g_bad_press
        $error("ec11_quad_gen: PRESS_CYCLES must be >= 1");
    end
    if (BOUNCE_CYCLES < 1) begin : g_bad_bounce
        $error("ec11_quad_gen: BOUNCE_CYCLES must be >= 1");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    rep_q, rep_d;
    logic          dir_q, dir_d;
    logic          fin_d;
    logic          fin_q;

    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    cmd_t          head;

    logic [1:0]    ab_new;
    logic          sw_new;
    logic [1:0]    ab_out;
    logic          sw_out;

    logic          a_q;
    logic          b_q;
    logic          sw_q;
    logic          done_q;
    logic          busy_q;

    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    ec11_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .push_i (push),
        .wdata_i({cmd_code, cmd_count}),
        .pop_i  (pop),
        .rdata_o(head),
        .full_o (full),
        .empty_o(empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        dir_d   = dir_q;
        fin_d   = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop   = 1'b1;
                    cnt_d = '0;
                    idx_d = 2'd0;
                    case (head.code)
                        CMD_LEFT, CMD_RIGHT: begin
                            if (head.count != 8'd0) begin
                                state_d = PHASE;
                                rep_d   = head.count;
                                dir_d   = (head.code == CMD_RIGHT);
                            end
                        end
                        CMD_PRESS: state_d = PRESS_LOW;
                        default:   state_d = IDLE;
                    endcase
                end
            end
            PHASE: begin
                if (cnt_q == PH_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 2'd3) begin
                        rep_d = rep_q - 8'd1;
                        idx_d = 2'd0;
                        if (rep_q == 8'd1) begin
                            state_d = IDLE;
                            fin_d   = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESS_LOW: begin
                if (cnt_q == PR_LAST) begin
                    cnt_d   = '0;
                    state_d = PRESS_HIGH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESS_HIGH: begin
                if (cnt_q == PR_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    fin_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            rep_q   <= 8'd0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        ab_new = 2'b11;
        sw_new = 1'b1;
        case (state_q)
            PHASE:     ab_new = seq_pat(dir_q, idx_q);
            PRESS_LOW: sw_new = 1'b0;
            default:   sw_new = 1'b1;
        endcase
    end

`ifdef EC11_QUAD_GEN_BOUNCE_EN
    localparam int BW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam logic [BW-1:0] B_LAST = BW'(BOUNCE_CYCLES - 1);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    bidx_q, bidx_d;
    logic [1:0]    ab_old;
    logic          sw_old;
    logic          glitch;

    // Bounce slots restart with every phase or press period.
    always_comb begin
        bcnt_d = bcnt_q;
        bidx_d = bidx_q;
        if (cnt_d == '0) begin
            bcnt_d = '0;
            bidx_d = 3'd0;
        end else if (bidx_q != 3'd4) begin
            if (bcnt_q == B_LAST) begin
                bcnt_d = '0;
                bidx_d = bidx_q + 3'd1;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
    end

    always_comb begin
        ab_old = 2'b11;
        sw_old = 1'b1;
        case (state_q)
            PHASE: begin
                if (idx_q != 2'd0) begin
                    ab_old = seq_pat(dir_q, idx_q - 2'd1);
                end
            end
            PRESS_HIGH: sw_old = 1'b0;
            default:    sw_old = 1'b1;
        endcase
    end

    assign glitch = (bidx_q != 3'd4) && bidx_q[0];
    assign ab_out = glitch ? ab_old : ab_new;
    assign sw_out = glitch ? sw_old : sw_new;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            bcnt_q <= '0;
            bidx_q <= 3'd0;
        end else begin
            bcnt_q <= bcnt_d;
            bidx_q <= bidx_d;
        end
    end
`else
    assign ab_out = ab_new;
    assign sw_out = sw_new;
`endif

    // Pins are registered one cycle behind the FSM for glitch-free edges.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            a_q    <= 1'b1;
            b_q    <= 1'b1;
            sw_q   <= 1'b1;
            fin_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= ab_out[1];
            b_q    <= ab_out[0];
            sw_q   <= sw_out;
            fin_q  <= fin_d;
            done_q <= fin_q;
            busy_q <= (state_q != IDLE) || !empty || fin_q;
        end
    end

    assign enc_a      = a_q;
    assign enc_b      = b_q;
    assign enc_sw     = sw_q;
    assign done_pulse = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ec11_quad_gen.sv
// Self-checking bench for ec11_quad_gen with short phase/press periods.
module tb_ec11_quad_gen;

    localparam int P  = 8;
    localparam int PC = 20;

    logic       sys_clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_code;
    logic [7:0] cmd_count;
    logic       enc_a;
    logic       enc_b;
    logic       enc_sw;
    logic       busy;
    logic       done_pulse;

    ec11_quad_gen #(
        .PHASE_CYCLES(P),
        .PRESS_CYCLES(PC),
        .FIFO_DEPTH  (4)
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_code  (cmd_code),
        .cmd_count (cmd_count),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .enc_sw    (enc_sw),
        .busy      (busy),
        .done_pulse(done_pulse)
    );

    typedef struct {
        logic [1:0] code;
        int         n;
    } exp_t;

    exp_t sb_q[$];
    int   n_tot;
    int   n_pass;
    int   cyc;
    int   tog_cnt;
    int   done_cnt;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: decode detent steps and presses, compare at each done_pulse.
    initial begin
        logic [1:0] pab;
        logic [1:0] ab;
        logic [1:0] first;
        logic       psw;
        int         nl;
        int         nr;
        int         np;
        int         el;
        int         er;
        int         ep;
        exp_t       e;
        pab = 2'b11;
        psw = 1'b1;
        first = 2'b11;
        nl = 0;
        nr = 0;
        np = 0;
        forever begin
            @(negedge sys_clk);
            if (!rst_n) begin
                pab = 2'b11;
                psw = 1'b1;
                first = 2'b11;
                nl = 0;
                nr = 0;
                np = 0;
            end else begin
                ab = {enc_a, enc_b};
                if (ab !== pab) begin
                    n_tot++;
                    if (ab[1] !== pab[1] && ab[0] !== pab[0])
                        $display("FAIL ab_one_pin: ab=%b after %b at cyc %0d, required single pin change",
                                 ab, pab, cyc);
                    else
                        n_pass++;
                    if (ab[1] !== pab[1]) tog_cnt++;
                    if (ab[0] !== pab[0]) tog_cnt++;
                    if (pab == 2'b11) first = ab;
                    if (ab == 2'b11) begin
                        if (first == 2'b10) nl++;
                        else if (first == 2'b01) nr++;
                    end
                end
                if (enc_sw !== psw) begin
                    tog_cnt++;
                    if (enc_sw === 1'b1) np++;
                end
                if (done_pulse === 1'b1) begin
                    done_cnt++;
                    n_tot++;
                    if (sb_q.size() == 0) begin
                        $display("FAIL sb_done: unexpected done_pulse at cyc %0d, required none", cyc);
                    end else begin
                        e  = sb_q.pop_front();
                        el = (e.code == 2'b01) ? e.n : 0;
                        er = (e.code == 2'b10) ? e.n : 0;
                        ep = (e.code == 2'b11) ? 1 : 0;
                        if (nl !== el || nr !== er || np !== ep)
                            $display("FAIL sb_cmd: got L%0d R%0d P%0d, required L%0d R%0d P%0d at cyc %0d",
                                     nl, nr, np, el, er, ep, cyc);
                        else
                            n_pass++;
                    end
                    nl = 0;
                    nr = 0;
                    np = 0;
                end
                pab = ab;
                psw = enc_sw;
            end
        end
    end

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge sys_clk);
    endtask

    task automatic send(input logic [1:0] c, input int n, output int t);
        int w;
        cmd_code  = c;
        cmd_count = n[7:0];
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 2000) begin
            @(negedge sys_clk);
            w++;
        end
        if (!cmd_ready) begin
            n_tot++;
            $display("FAIL send_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, w);
            t = -1;
            return;
        end
        @(posedge sys_clk);
        #1;
        t = cyc;
        if (c == 2'b11 || ((c == 2'b01 || c == 2'b10) && n != 0))
            sb_q.push_back('{code: c, n: n});
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while ((busy !== 1'b0 || sb_q.size() != 0) && w < 3000) begin
            @(negedge sys_clk);
            w++;
        end
        n_tot++;
        if (busy !== 1'b0 || sb_q.size() != 0)
            $display("FAIL %s_idle: busy=%b pending=%0d, required 0/0", name, busy, sb_q.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_tot++;
        if ({enc_a, enc_b, enc_sw} !== 3'b111)
            $display("FAIL reset_pins: got %b, required 111", {enc_a, enc_b, enc_sw});
        else n_pass++;
        n_tot++;
        if ({cmd_ready, busy, done_pulse} !== 3'b100)
            $display("FAIL reset_ctl: ready/busy/done=%b, required 100", {cmd_ready, busy, done_pulse});
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_left_single();
        int t;
        logic [1:0] want_ab [5];
        int         want_at [5];
        want_ab = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
        want_at = '{1, 2, 2 + P, 2 + 2 * P, 2 + 3 * P};
        send(2'b01, 1, t);
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_to(t + want_at[i]);
            n_tot++;
            if ({enc_a, enc_b} !== want_ab[i])
                $display("FAIL left_ab@T+%0d: got %b, required %b", want_at[i], {enc_a, enc_b}, want_ab[i]);
            else n_pass++;
        end
        wait_to(t + 1 + 4 * P);
        n_tot++;
        if (done_pulse !== 1'b0)
            $display("FAIL left_done_early: done=%b at T+%0d, required 0", done_pulse, 1 + 4 * P);
        else n_pass++;
        wait_to(t + 2 + 4 * P);
        n_tot++;
        if ({done_pulse, busy} !== 2'b11)
            $display("FAIL left_done: done/busy=%b at T+%0d, required 11", {done_pulse, busy}, 2 + 4 * P);
        else n_pass++;
        wait_to(t + 3 + 4 * P);
        n_tot++;
        if ({done_pulse, busy} !== 2'b00)
            $display("FAIL left_after: done/busy=%b at T+%0d, required 00", {done_pulse, busy}, 3 + 4 * P);
        else n_pass++;
    endtask

    task automatic test_right_three();
        int t;
        int tog0;
        int d0;
        tog0 = tog_cnt;
        d0   = done_cnt;
        send(2'b10, 3, t);
        cmd_valid = 1'b0;
        wait_to(t + 2);
        n_tot++;
        if ({enc_a, enc_b} !== 2'b01)
            $display("FAIL right_first: got %b, required 01", {enc_a, enc_b});
        else n_pass++;
        wait_to(t + 2 + 12 * P);
        n_tot++;
        if (done_pulse !== 1'b1)
            $display("FAIL right_done_time: done=%b at T+%0d, required 1", done_pulse, 2 + 12 * P);
        else n_pass++;
        wait_idle("right");
        n_tot++;
        if (tog_cnt - tog0 !== 12 || done_cnt - d0 !== 1)
            $display("FAIL right_counts: toggles=%0d dones=%0d, required 12/1", tog_cnt - tog0, done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_press();
        int t;
        logic want_sw [5];
        int   want_at [5];
        want_sw = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        want_at = '{1, 2, 1 + PC, 2 + PC, 1 + 2 * PC};
        send(2'b11, 7, t);
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_to(t + want_at[i]);
            n_tot++;
            if (enc_sw !== want_sw[i])
                $display("FAIL press_sw@T+%0d: got %b, required %b", want_at[i], enc_sw, want_sw[i]);
            else n_pass++;
        end
        wait_to(t + 2 + 2 * PC);
        n_tot++;
        if (done_pulse !== 1'b1)
            $display("FAIL press_done: done=%b at T+%0d, required 1", done_pulse, 2 + 2 * PC);
        else n_pass++;
        wait_idle("press");
    endtask

    task automatic test_back_to_back();
        int t0;
        int t;
        int d0;
        logic [1:0] codes [5];
        int         cnts  [5];
        codes = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
        cnts  = '{1, 2, 0, 1, 1};
        d0 = done_cnt;
        send(codes[0], cnts[0], t0);
        for (int i = 1; i < 5; i++) send(codes[i], cnts[i], t);
        n_tot++;
        if (t - t0 !== 4)
            $display("FAIL b2b_accept: 5th accepted at T+%0d, required T+4", t - t0);
        else n_pass++;
        n_tot++;
        if (cmd_ready !== 1'b0)
            $display("FAIL b2b_full: cmd_ready=%b, required 0", cmd_ready);
        else n_pass++;
        send(2'b01, 2, t);
        cmd_valid = 1'b0;
        n_tot++;
        if (t - t0 !== 3 + 4 * P)
            $display("FAIL b2b_held: 6th accepted at T+%0d, required T+%0d", t - t0, 3 + 4 * P);
        else n_pass++;
        wait_idle("b2b");
        n_tot++;
        if (done_cnt - d0 !== 6)
            $display("FAIL b2b_dones: got %0d, required 6", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int t;
        int t2;
        int tog0;
        int d0;
        send(2'b01, 1, t);
        send(2'b10, 2, t2);
        cmd_valid = 1'b0;
        wait_to(t + 2 + 2 * P + P / 2 - 1);
        rst_n = 1'b0;
        sb_q.delete();
        @(posedge sys_clk);
        #1;
        n_tot++;
        if ({enc_a, enc_b, enc_sw, busy} !== 4'b1110)
            $display("FAIL rstmid_out: a/b/sw/busy=%b, required 1110", {enc_a, enc_b, enc_sw, busy});
        else n_pass++;
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        tog0 = tog_cnt;
        d0   = done_cnt;
        repeat (60) @(negedge sys_clk);
        n_tot++;
        if (tog_cnt - tog0 !== 0 || done_cnt - d0 !== 0 || busy !== 1'b0)
            $display("FAIL rstmid_quiet: toggles=%0d dones=%0d busy=%b, required 0/0/0",
                     tog_cnt - tog0, done_cnt - d0, busy);
        else n_pass++;
    endtask

    task automatic test_discard();
        int t;
        int tog0;
        int d0;
        tog0 = tog_cnt;
        d0   = done_cnt;
        send(2'b00, 5, t);
        send(2'b01, 0, t);
        cmd_valid = 1'b0;
        wait_to(t + 20);
        n_tot++;
        if (tog_cnt - tog0 !== 0 || done_cnt - d0 !== 0)
            $display("FAIL discard: toggles=%0d dones=%0d, required 0/0", tog_cnt - tog0, done_cnt - d0);
        else n_pass++;
        n_tot++;
        if ({busy, cmd_ready} !== 2'b01)
            $display("FAIL discard_idle: busy/ready=%b, required 01", {busy, cmd_ready});
        else n_pass++;
    endtask

    initial begin
        n_tot     = 0;
        n_pass    = 0;
        tog_cnt   = 0;
        done_cnt  = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_code  = 2'b00;
        cmd_count = 8'd0;
        test_reset();
        test_left_single();
        test_right_three();
        test_press();
        test_back_to_back();
        test_discard();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
